// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and commit bundle of the reorder buffer.
// The ROB connects through the slave modport and its driver through master.
interface reorder_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) ();
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [REG_W-1:0]  alloc_rd;
  logic              alloc_regWrite;
  logic [TAG_W-1:0]  alloc_tag;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        wb_flags;
  logic              wb_mispredict;

  logic              commit_valid;
  logic              commit_ready;
  logic [REG_W-1:0]  commit_rd;
  logic              commit_regWrite;
  logic [DATA_W-1:0] commit_data;
  logic [3:0]        commit_flags;

  logic              flush;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport slave (
    input  alloc_valid, alloc_rd, alloc_regWrite,
    input  wb_valid, wb_tag, wb_data, wb_flags, wb_mispredict,
    input  commit_ready,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_rd, commit_regWrite, commit_data, commit_flags,
    output flush, count, empty, full
  );

  modport master (
    output alloc_valid, alloc_rd, alloc_regWrite,
    output wb_valid, wb_tag, wb_data, wb_flags, wb_mispredict,
    output commit_ready,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_rd, commit_regWrite, commit_data, commit_flags,
    input  flush, count, empty, full
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: allocates at tail, completes out of order,
// commits from head, and flushes everything when a mispredicted branch commits.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  reorder_buffer_if.slave    rob
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  mispred_q, mispred_d;
  logic [DEPTH-1:0]  regwrite_q, regwrite_d;
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [REG_W-1:0]  rd_d    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [3:0]        flags_q [DEPTH];
  logic [3:0]        flags_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full, empty, commit_valid, commit_fire, flush_w, alloc_ready, alloc_fire;

  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    empty        = (count_q == '0);
    commit_valid = valid_q[head_q] && done_q[head_q];
    commit_fire  = commit_valid && rob.commit_ready;
    flush_w      = commit_fire && mispred_q[head_q];
    // Full blocks allocation even when the head retires in the same cycle.
    alloc_ready  = !full && !flush_w;
    alloc_fire   = rob.alloc_valid && alloc_ready;
  end

  always_comb begin
    rob.alloc_ready     = alloc_ready;
    rob.alloc_tag       = tail_q;
    rob.commit_valid    = commit_valid;
    rob.commit_rd       = rd_q[head_q];
    rob.commit_regWrite = regwrite_q[head_q];
    rob.commit_data     = data_q[head_q];
    rob.commit_flags    = flags_q[head_q];
    rob.flush           = flush_w;
    rob.count           = count_q;
    rob.empty           = empty;
    rob.full            = full;
  end

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    mispred_d  = mispred_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    data_d     = data_q;
    flags_d    = flags_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush_w) begin
      valid_d   = '0;
      done_d    = '0;
      mispred_d = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      // Tail is never valid when allocation is possible, so a writeback aimed
      // at the entry being allocated this cycle falls through the valid check.
      if (rob.wb_valid && valid_q[rob.wb_tag]) begin
        done_d[rob.wb_tag]    = 1'b1;
        mispred_d[rob.wb_tag] = rob.wb_mispredict;
        data_d[rob.wb_tag]    = rob.wb_data;
        flags_d[rob.wb_tag]   = rob.wb_flags;
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        done_d[tail_q]     = 1'b0;
        mispred_d[tail_q]  = 1'b0;
        regwrite_d[tail_q] = rob.alloc_regWrite;
        rd_d[tail_q]       = rob.alloc_rd;
        tail_d             = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Payload is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    regwrite_q <= regwrite_d;
    rd_q       <= rd_d;
    data_q     <= data_d;
    flags_q    <= flags_d;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic, all checked
// against a queue-of-entries model of in-order retirement.
module tb_reorder_buffer;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) rif ();
  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

  typedef struct {
    int                tag;
    logic [REG_W-1:0]  rd;
    logic              rw;
    bit                done;
    logic [DATA_W-1:0] data;
    logic [3:0]        flags;
    bit                mp;
  } ent_t;

  ent_t q[$];
  int   next_tag;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_commit_valid();
    return q.size() > 0 && q[0].done;
  endfunction

  function automatic bit exp_flush();
    return exp_commit_valid() && q[0].mp && rif.commit_ready;
  endfunction

  task automatic idle();
    rif.alloc_valid    = 1'b0;
    rif.alloc_rd       = '0;
    rif.alloc_regWrite = 1'b0;
    rif.wb_valid       = 1'b0;
    rif.wb_tag         = '0;
    rif.wb_data        = '0;
    rif.wb_flags       = '0;
    rif.wb_mispredict  = 1'b0;
    rif.commit_ready   = 1'b0;
  endtask

  task automatic compare_outputs();
    bit cv;
    cv = exp_commit_valid();
    check("count",        rif.count, q.size());
    check("empty",        rif.empty, q.size() == 0);
    check("full",         rif.full, q.size() == DEPTH);
    check("alloc_ready",  rif.alloc_ready, q.size() < DEPTH && !exp_flush());
    check("alloc_tag",    rif.alloc_tag, next_tag);
    check("commit_valid", rif.commit_valid, cv);
    check("flush",        rif.flush, exp_flush());
    if (cv) begin
      check("commit_rd",       rif.commit_rd, q[0].rd);
      check("commit_regWrite", rif.commit_regWrite, q[0].rw);
      check("commit_data",     rif.commit_data, q[0].data);
      check("commit_flags",    rif.commit_flags, q[0].flags);
    end
  endtask

  task automatic model_edge();
    bit cfire, fl, afire;
    if (reset) begin
      q.delete();
      next_tag = 0;
      return;
    end
    cfire = exp_commit_valid() && rif.commit_ready;
    fl    = cfire && q[0].mp;
    afire = rif.alloc_valid && q.size() < DEPTH && !fl;
    if (fl) begin
      q.delete();
      next_tag = 0;
      return;
    end
    if (rif.wb_valid) begin
      foreach (q[i]) begin
        if (q[i].tag == int'(rif.wb_tag)) begin
          ent_t e;
          e       = q[i];
          e.done  = 1'b1;
          e.data  = rif.wb_data;
          e.flags = rif.wb_flags;
          e.mp    = rif.wb_mispredict;
          q[i]    = e;
        end
      end
    end
    if (cfire) void'(q.pop_front());
    if (afire) begin
      ent_t e;
      e.tag   = next_tag;
      e.rd    = rif.alloc_rd;
      e.rw    = rif.alloc_regWrite;
      e.done  = 1'b0;
      e.data  = '0;
      e.flags = '0;
      e.mp    = 1'b0;
      q.push_back(e);
      next_tag = (next_tag + 1) % DEPTH;
    end
  endtask

  // Inputs are set just after a falling edge; outputs are checked 1ns later.
  task automatic step();
    #1 compare_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_wb(input int tag, input logic [63:0] data, input bit mp);
    rif.wb_valid      = 1'b1;
    rif.wb_tag        = tag[2:0];
    rif.wb_data       = data;
    rif.wb_flags      = data[3:0];
    rif.wb_mispredict = mp;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ooo_data [3];
    ooo_data[0] = 64'h22; ooo_data[1] = 64'h11; ooo_data[2] = 64'h00;

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    q.delete();
    next_tag = 0;
    @(negedge clk);
    reset = 1'b0;

    #1;
    check("rst_alloc_ready",  rif.alloc_ready, 1);
    check("rst_alloc_tag",    rif.alloc_tag, 0);
    check("rst_commit_valid", rif.commit_valid, 0);
    check("rst_flush",        rif.flush, 0);
    check("rst_empty",        rif.empty, 1);
    check("rst_full",         rif.full, 0);
    check("rst_count",        rif.count, 0);

    // Fill all eight entries with no writeback.
    for (int i = 0; i < DEPTH; i++) begin
      rif.alloc_valid    = 1'b1;
      rif.alloc_rd       = REG_W'(i + 1);
      rif.alloc_regWrite = 1'b1;
      #1 check("fill_tag", rif.alloc_tag, i);
      step();
    end
    idle();
    #1;
    check("fill_full",        rif.full, 1);
    check("fill_alloc_ready", rif.alloc_ready, 0);
    check("fill_count",       rif.count, DEPTH);
    check("fill_commit_valid", rif.commit_valid, 0);
    step();

    // Out-of-order completion of tags 2,1,0, then in-order retirement.
    for (int k = 0; k < 3; k++) begin
      idle();
      rif.commit_ready = 1'b1;
      do_wb(2 - k, ooo_data[k], 1'b0);
      step();
    end
    idle();
    rif.commit_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ooo_commit_valid", rif.commit_valid, 1);
      check("ooo_rd",   rif.commit_rd, k + 1);
      check("ooo_data", rif.commit_data, ooo_data[2-k]);
      step();
    end
    idle();
    step();

    // Refill to full, then commit and allocate in the same cycle.
    for (int i = 0; i < 3; i++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_rd    = REG_W'(20 + i);
      step();
    end
    idle();
    do_wb(3, 64'hdead_beef, 1'b0);
    step();
    idle();
    rif.commit_ready = 1'b1;
    rif.alloc_valid  = 1'b1;
    rif.alloc_rd     = 5'd30;
    #1;
    check("fullc_alloc_ready",  rif.alloc_ready, 0);
    check("fullc_commit_valid", rif.commit_valid, 1);
    step();
    rif.commit_ready = 1'b0;
    #1;
    check("fullc_count",       rif.count, 7);
    check("fullc_alloc_ready2", rif.alloc_ready, 1);
    step();

    // Reset with live entries and a simultaneous writeback.
    idle();
    do_wb(4, 64'h44, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    #1;
    check("rstlive_count",        rif.count, 0);
    check("rstlive_commit_valid", rif.commit_valid, 0);
    check("rstlive_alloc_tag",    rif.alloc_tag, 0);
    step();

    // Mispredict on tag 1 among five entries.
    for (int i = 0; i < 5; i++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_rd    = REG_W'(i + 10);
      step();
    end
    idle();
    for (int i = 4; i >= 0; i--) begin
      do_wb(i, 64'(100 + i), i == 1);
      step();
    end
    idle();
    rif.commit_ready = 1'b1;
    step();
    #1;
    check("mp_flush", rif.flush, 1);
    check("mp_rd",    rif.commit_rd, 11);
    step();
    #1;
    check("mp_count", rif.count, 0);
    check("mp_empty", rif.empty, 1);
    for (int i = 0; i < 4; i++) step();

    // Random traffic, including wraparound and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset              = ($urandom_range(299) == 0);
      rif.alloc_valid    = ($urandom_range(3) != 0);
      rif.alloc_rd       = REG_W'($urandom);
      rif.alloc_regWrite = 1'($urandom);
      rif.commit_ready   = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1) begin
        int t;
        if (q.size() > 0 && $urandom_range(7) != 0)
          t = q[$urandom_range(q.size() - 1)].tag;
        else
          t = $urandom_range(DEPTH - 1);
        do_wb(t, {$urandom, $urandom}, $urandom_range(19) == 0);
      end
      step();
    end
    reset = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 8, entry count; the value SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_W, default 64, result width.
REQ-003 Parameter REG_W, default 5, destination register index width.
REQ-004 Derived TAG_W = log2(DEPTH); CNT_W = TAG_W+1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 alloc_valid  in  1  dispatch requests an entry.
REQ-008 alloc_ready  out  1  entry may be allocated this cycle.
REQ-009 alloc_rd  in  REG_W  destination register of dispatched instr.
REQ-010 alloc_regWrite  in  1  instr writes the register file.
REQ-011 alloc_tag  out  TAG_W  index that an allocation this cycle receives (current tail).
REQ-012 wb_valid  in  1  execution result available.
REQ-013 wb_tag  in  TAG_W  entry being completed.
REQ-014 wb_data  in  DATA_W  result value.
REQ-015 wb_flags  in  4  NZCV flags of the result.
REQ-016 wb_mispredict  in  1  completed instr is a mispredicted branch.
REQ-017 commit_valid  out  1  head entry is complete and presented.
REQ-018 commit_ready  in  1  register file accepts commit.
REQ-019 commit_rd / commit_regWrite / commit_data / commit_flags  out  REG_W/1/DATA_W/4  head entry fields.
REQ-020 flush  out  1  pipeline flush request.
REQ-021 count  out  CNT_W  occupied entries; empty out 1; full out 1.

Function
REQ-022 Each entry SHALL hold valid, done, mispred, rd, regWrite, data, flags; head and tail pointers SHALL be TAG_W bits and wrap DEPTH-1 -> 0.
REQ-023 alloc_ready SHALL equal !full && !flush; full is count==DEPTH, empty is count==0.
REQ-024 Alloc fire (alloc_valid && alloc_ready): entry[tail] gets valid=1, done=0, mispred=0, rd, regWrite; tail increments.
REQ-025 Full state SHALL block allocation even when a commit fires in the same cycle.
REQ-026 Writeback to a valid entry SHALL set done=1 and store data, flags, mispred; writeback to an invalid entry (including tail being allocated the same cycle) SHALL be ignored.
REQ-027 commit_valid SHALL equal entry[head].valid && entry[head].done; commit_* outputs SHALL be combinational from entry[head].
REQ-028 Commit fire (commit_valid && commit_ready): entry[head].valid clears; head increments.
REQ-029 Writeback to the head entry SHALL make commit_valid rise no earlier than the following cycle (1-cycle wb-to-commit latency).
REQ-030 count SHALL go +1 on alloc fire, -1 on commit fire, unchanged when both or neither fire.
REQ-031 flush SHALL be asserted combinationally in any cycle where commit fires on an entry with mispred=1.
REQ-032 On the edge ending a flush cycle, all entries SHALL be invalidated, head=tail=0, count=0; a writeback in that cycle SHALL be discarded.
REQ-033 Committed data and flags SHALL pass through unmodified; no arithmetic on payload.

Reset
REQ-034 While reset is high at a rising edge: all valid/done/mispred clear, head=tail=0, count=0.
REQ-035 After reset: alloc_ready=1, alloc_tag=0, commit_valid=0, flush=0, empty=1, full=0, count=0.
REQ-036 Reset SHALL override any simultaneous alloc, writeback, commit or flush.

Verification
REQ-037 DEPTH=8: allocate 8 (rd=1..8), no wb -> alloc_tag 0..7, full=1, alloc_ready=0, count=8, commit_valid=0.
REQ-038 Out-of-order wb to tags 2,1,0 with data 0x22,0x11,0x00, commit_ready=1 -> commits in order rd=1,2,3 with data 0x00,0x11,0x22, one per cycle, starting the cycle after tag 0 wb.
REQ-039 Wrap: 10 alloc/wb/commit rounds -> alloc_tag sequence 0..7,0,1; count never exceeds 8; no commit lost or duplicated.
REQ-040 Full ROB, head done, commit_ready=1, alloc_valid=1 -> commit fires, no alloc that cycle, count 8->7; alloc succeeds next cycle.
REQ-041 Five entries, tag 1 wb with mispredict=1, tags 0..4 done -> commit tag0, commit tag1 with flush=1, next cycle count=0, empty=1, tags 2..4 never commit.
REQ-042 Reset asserted with 4 entries live and wb_valid=1 -> next cycle count=0, commit_valid=0, alloc_tag=0.
